// File: rtl/wishbone_slave_ram_pkg.sv
//==============================================================================
// Module : wb_pkg
// Brief  : Shared Wishbone constants, FSM state encodings and command opcodes.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package wb_pkg;

    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_SEL_WIDTH  = 4;

    typedef enum logic [1:0] {
        WB_S_IDLE = 2'd0,
        WB_S_WAIT = 2'd1,
        WB_S_RESP = 2'd2
    } wb_state_e;

    // Command word shared with wishbone_master: {op[1:0], payload[31:0]}.
    localparam logic [33:0] WB_CMD_NOP   = 34'h0_0000_0000;
    localparam logic [33:0] WB_CMD_READ  = 34'h1_0000_0000;
    localparam logic [33:0] WB_CMD_WRITE = 34'h2_0000_0000;

    function automatic logic [1:0] wb_cmd_op(input logic [33:0] cmd);
        return cmd[33:32];
    endfunction

endpackage

`default_nettype wire

// File: rtl/wishbone_slave_ram_if.sv
//==============================================================================
// Module : wishbone_slave_ram_if
// Brief  : Pipelined Wishbone bus bundle with master/slave modports.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface wishbone_slave_ram_if
    import wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
);

    logic                     cyc;
    logic                     stb;
    logic                     we;
    logic [ADDR_WIDTH-1:0]    addr;
    logic [WB_DATA_WIDTH-1:0] wdata;
    logic [WB_SEL_WIDTH-1:0]  sel;
    logic                     ack;
    logic                     err;
    logic                     stall;
    logic [WB_DATA_WIDTH-1:0] rdata;

    modport master (
        output cyc, stb, we, addr, wdata, sel,
        input  ack, err, stall, rdata
    );

    modport slave (
        input  cyc, stb, we, addr, wdata, sel,
        output ack, err, stall, rdata
    );

endinterface

`default_nettype wire

// File: rtl/wishbone_slave_ram_array.sv
//==============================================================================
// Module : wb_ram_array
// Brief  : Synchronous single-port 32-bit RAM with per-byte write enables.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_ram_array
    import wb_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  wire logic                     clk,
    input  wire logic                     en,
    input  wire logic [WB_SEL_WIDTH-1:0]  we,
    input  wire logic [ADDR_WIDTH-1:0]    addr,
    input  wire logic [WB_DATA_WIDTH-1:0] wdata,
    output logic      [WB_DATA_WIDTH-1:0] rdata
);

    logic [WB_DATA_WIDTH-1:0] mem [DEPTH];

    // Read-before-write: rdata returns the old word when a write shares the cycle.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int b = 0; b < WB_SEL_WIDTH; b++) begin
                if (we[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[addr];
        end
    end

endmodule

`default_nettype wire

// File: rtl/wishbone_slave_ram.sv
//==============================================================================
// Module : wishbone_slave_ram
// Brief  : Pipelined Wishbone slave RAM with programmable wait states.
//          Optional byte-lane writes via macro WB_SLAVE_RAM_BYTE_SEL_EN.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wishbone_slave_ram
    import wb_pkg::*;
#(
    parameter int MEMORY_DEPTH = 1024,
    parameter int ADDR_WIDTH   = 10,
    parameter int WAIT_STATES  = 0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    wishbone_slave_ram_if.slave  bus
);

    localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(MEMORY_DEPTH);
    localparam logic [3:0]          WAIT_INIT = 4'(WAIT_STATES - 1);

    wb_state_e                 state;
    wb_state_e                 state_nxt;
    logic [3:0]                cnt;
    logic [3:0]                cnt_nxt;
    logic                      accept;
    logic                      enter_resp;

    logic [ADDR_WIDTH-1:0]     req_addr;
    logic                      req_we;
    logic [WB_DATA_WIDTH-1:0]  req_wdata;
    logic [ADDR_WIDTH-1:0]     cur_addr;
    logic                      cur_we;
    logic [WB_DATA_WIDTH-1:0]  cur_wdata;
    logic                      cur_oor;
    logic [WB_SEL_WIDTH-1:0]   lane_sel;

    logic [WB_SEL_WIDTH-1:0]   ram_we;
    logic                      ram_en;
    logic [WB_DATA_WIDTH-1:0]  ram_q;

    logic                      ack_q;
    logic                      err_q;
    logic [WB_DATA_WIDTH-1:0]  rdata_q;

    assign accept = (state == WB_S_IDLE) && bus.cyc && bus.stb;

    // With zero wait states RESP is entered on the accept edge, so the live bus
    // fields must feed the RAM directly; otherwise the captured copy is used.
    assign cur_addr  = (state == WB_S_IDLE) ? bus.addr  : req_addr;
    assign cur_we    = (state == WB_S_IDLE) ? bus.we    : req_we;
    assign cur_wdata = (state == WB_S_IDLE) ? bus.wdata : req_wdata;
    assign cur_oor   = !({1'b0, cur_addr} < DEPTH_LIM);

`ifdef WB_SLAVE_RAM_BYTE_SEL_EN
    logic [WB_SEL_WIDTH-1:0] req_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sel <= '0;
        end else if (accept) begin
            req_sel <= bus.sel;
        end
    end

    assign lane_sel = (state == WB_S_IDLE) ? bus.sel : req_sel;
`else
    assign lane_sel = {WB_SEL_WIDTH{1'b1}};
`endif

    assign ram_en = enter_resp && !cur_oor;
    assign ram_we = (ram_en && cur_we) ? lane_sel : '0;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        case (state)
            WB_S_IDLE: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_nxt = WB_S_WAIT;
                        cnt_nxt   = WAIT_INIT;
                    end else begin
                        state_nxt  = WB_S_RESP;
                        enter_resp = 1'b1;
                    end
                end
            end
            WB_S_WAIT: begin
                if (!bus.cyc) begin
                    state_nxt = WB_S_IDLE;
                    cnt_nxt   = 4'd0;
                end else if (cnt == 4'd0) begin
                    state_nxt  = WB_S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            WB_S_RESP: begin
                state_nxt = WB_S_IDLE;
            end
            default: begin
                state_nxt = WB_S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= WB_S_IDLE;
            cnt       <= 4'd0;
            req_addr  <= '0;
            req_we    <= 1'b0;
            req_wdata <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                req_addr  <= bus.addr;
                req_we    <= bus.we;
                req_wdata <= bus.wdata;
            end
            ack_q <= (state == WB_S_RESP) && !cur_oor;
            err_q <= (state == WB_S_RESP) && cur_oor;
            if ((state == WB_S_RESP) && !cur_we && !cur_oor) begin
                rdata_q <= ram_q;
            end
        end
    end

    assign bus.ack   = ack_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdata_q;
    assign bus.stall = (state != WB_S_IDLE);

    wb_ram_array #(
        .DEPTH      (MEMORY_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (cur_addr),
        .wdata (cur_wdata),
        .rdata (ram_q)
    );

endmodule

`default_nettype wire

// File: tb/tb_wishbone_slave_ram.sv
//==============================================================================
// Module : tb_wishbone_slave_ram
// Brief  : Scoreboard bench driving three slave instances (0, 2 and 3 wait states).
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wishbone_slave_ram;
    import wb_pkg::*;

    typedef struct {
        logic        rd;
        logic        err;
        logic [31:0] data;
    } sb_t;

`ifdef WB_SLAVE_RAM_BYTE_SEL_EN
    localparam logic [31:0] EXP_BSEL = 32'hAA22CC44;
    localparam logic [31:0] EXP_SEL0 = 32'hAA22CC44;
`else
    localparam logic [31:0] EXP_BSEL = 32'h11223344;
    localparam logic [31:0] EXP_SEL0 = 32'hFFFFFFFF;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          dsel = 0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic        we = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  sel = '0;
    logic        ack, err, stall;
    logic [31:0] rdata;

    int total = 0;
    int bad   = 0;
    sb_t sb[$];

    always #5 clk = ~clk;

    wishbone_slave_ram_if #(.ADDR_WIDTH(10)) bus0 ();
    wishbone_slave_ram_if #(.ADDR_WIDTH(10)) bus2 ();
    wishbone_slave_ram_if #(.ADDR_WIDTH(10)) bus3 ();

    assign bus0.cyc = cyc & (dsel == 0);
    assign bus0.stb = stb & (dsel == 0);
    assign bus0.we = we;
    assign bus0.addr = addr;
    assign bus0.wdata = wdata;
    assign bus0.sel = sel;
    assign bus2.cyc = cyc & (dsel == 1);
    assign bus2.stb = stb & (dsel == 1);
    assign bus2.we = we;
    assign bus2.addr = addr;
    assign bus2.wdata = wdata;
    assign bus2.sel = sel;
    assign bus3.cyc = cyc & (dsel == 2);
    assign bus3.stb = stb & (dsel == 2);
    assign bus3.we = we;
    assign bus3.addr = addr;
    assign bus3.wdata = wdata;
    assign bus3.sel = sel;

    always_comb begin
        ack = bus0.ack; err = bus0.err; stall = bus0.stall; rdata = bus0.rdata;
        if (dsel == 1) begin
            ack = bus2.ack; err = bus2.err; stall = bus2.stall; rdata = bus2.rdata;
        end else if (dsel == 2) begin
            ack = bus3.ack; err = bus3.err; stall = bus3.stall; rdata = bus3.rdata;
        end
    end

    wishbone_slave_ram #(.MEMORY_DEPTH(768), .ADDR_WIDTH(10), .WAIT_STATES(0))
        u_d0 (.clk(clk), .rst(rst), .bus(bus0));
    wishbone_slave_ram #(.MEMORY_DEPTH(1024), .ADDR_WIDTH(10), .WAIT_STATES(2))
        u_d2 (.clk(clk), .rst(rst), .bus(bus2));
    wishbone_slave_ram #(.MEMORY_DEPTH(1024), .ADDR_WIDTH(10), .WAIT_STATES(3))
        u_d3 (.clk(clk), .rst(rst), .bus(bus3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%08h expected=%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One full transaction; expected response is queued before the request is driven.
    task automatic xfer(input logic w, input logic [9:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err, input logic [31:0] exp_d,
                        input int lat);
        sb_t e;
        int  n;
        int  stalls;
        e.rd = !w; e.err = exp_err; e.data = exp_d;
        sb.push_back(e);
        @(negedge clk);
        check("idle_stall", 32'(stall), 32'd0);
        cyc = 1'b1; stb = 1'b1; we = w; addr = a; wdata = d; sel = s;
        @(posedge clk); #1;
        stb = 1'b0;
        n = 0; stalls = 0;
        while (!(ack || err) && n < 32) begin
            if (stall) stalls++;
            @(posedge clk); #1;
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("stall_cycles", 32'(stalls), 32'(lat));
        e = sb.pop_front();
        check("ack", 32'(ack), 32'(!e.err));
        check("err", 32'(err), 32'(e.err));
        if (e.rd && !e.err) check("rdata", rdata, e.data);
        @(negedge clk);
        cyc = 1'b0;
        @(posedge clk); #1;
        check("resp_pulse", 32'(ack | err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hits;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            dsel = i; #1;
            check("rst_ack", 32'(ack), 32'd0);
            check("rst_err", 32'(err), 32'd0);
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end
        rst = 1'b0;

        // Zero wait states: write then read back.
        dsel = 0;
        xfer(1'b1, 10'h2AA, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0, 1);
        xfer(1'b0, 10'h2AA, 32'h0, 4'hF, 1'b0, 32'hAABBCCDD, 1);

        // Byte lanes, including an all-zero select.
        xfer(1'b1, 10'h010, 32'hAABBCCDD, 4'hF, 1'b0, 32'h0, 1);
        xfer(1'b1, 10'h010, 32'h11223344, 4'b0101, 1'b0, 32'h0, 1);
        xfer(1'b0, 10'h010, 32'h0, 4'hF, 1'b0, EXP_BSEL, 1);
        xfer(1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000, 1'b0, 32'h0, 1);
        xfer(1'b0, 10'h010, 32'h0, 4'hF, 1'b0, EXP_SEL0, 1);

        // Out of range with a 768-word memory.
        xfer(1'b1, 10'h2FF, 32'h0BADF00D, 4'hF, 1'b0, 32'h0, 1);
        xfer(1'b1, 10'h300, 32'h55555555, 4'hF, 1'b1, 32'h0, 1);
        xfer(1'b0, 10'h2FF, 32'h0, 4'hF, 1'b0, 32'h0BADF00D, 1);
        xfer(1'b0, 10'h3FF, 32'h0, 4'hF, 1'b1, 32'h0, 1);
        check("oor_rdata_hold", rdata, 32'h0BADF00D);

        // Abort during WAIT with two wait states.
        dsel = 1;
        xfer(1'b1, 10'h020, 32'h01020304, 4'hF, 1'b0, 32'h0, 3);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 10'h020; wdata = 32'hDEADBEEF; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        @(negedge clk);
        cyc = 1'b0;
        hits = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (ack || err) hits++;
        end
        check("abort_no_resp", 32'(hits), 32'd0);
        check("abort_idle", 32'(stall), 32'd0);
        xfer(1'b0, 10'h020, 32'h0, 4'hF, 1'b0, 32'h01020304, 3);

        // Three wait states, then reset mid-WAIT during a write.
        dsel = 2;
        xfer(1'b1, 10'h001, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0, 4);
        xfer(1'b0, 10'h001, 32'h0, 4'hF, 1'b0, 32'hCAFEF00D, 4);
        xfer(1'b1, 10'h005, 32'h5A5A5A5A, 4'hF, 1'b0, 32'h0, 4);
        xfer(1'b0, 10'h005, 32'h0, 4'hF, 1'b0, 32'h5A5A5A5A, 4);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = 10'h005; wdata = 32'h12345678; sel = 4'hF;
        @(posedge clk); #1;
        stb = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ack", 32'(ack), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_stall", 32'(stall), 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        check("midrst_state", 32'(u_d3.state), 32'(WB_S_IDLE));
        @(negedge clk);
        rst = 1'b0;
        cyc = 1'b0;
        xfer(1'b0, 10'h005, 32'h0, 4'hF, 1'b0, 32'h5A5A5A5A, 4);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
